// File: rtl/msrv32_pipe_ctrl.sv
// Purpose : pipeline hold/flush controller for the 3-stage msrv32 core (PC, reg_block_1, reg_block_2).
// Latency : Mealy; stall/flush controls respond in the same cycle the cause is presented.
// Backpres: data-bus wait freezes every stage, fetch wait injects bubbles, load-use hazards stall one cycle.
//
// Ports:
//   clk_in, reset_n_in                    clock, async active-low reset
//   instr_hready_in, data_hready_in       instruction / data bus ready
//   branch_taken_in, trap_taken_in        redirect requests
//   ex_load_in, ex_rd_addr_in             load sitting in reg_block_2 and its destination
//   id_rs{1,2}_addr_in, id_rs{1,2}_used_in  stage-2 source operands
//   perf_clr_in                           clears the stall-cycle counter
//   pc_hold_out, reg{1,2}_en_out, reg{1,2}_flush_out   pipeline register controls
//   bus_err_out                           one-cycle pulse on data-wait timeout
//   state_out                             action taken in the previous cycle
//   stall_cycles_out                      saturating count of held cycles
module msrv32_pipe_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             instr_hready_in,
    input  logic             data_hready_in,
    input  logic             branch_taken_in,
    input  logic             trap_taken_in,
    input  logic             ex_load_in,
    input  logic [4:0]       ex_rd_addr_in,
    input  logic [4:0]       id_rs1_addr_in,
    input  logic [4:0]       id_rs2_addr_in,
    input  logic             id_rs1_used_in,
    input  logic             id_rs2_used_in,
    input  logic             perf_clr_in,
    output logic             pc_hold_out,
    output logic             reg1_en_out,
    output logic             reg1_flush_out,
    output logic             reg2_en_out,
    output logic             reg2_flush_out,
    output logic             bus_err_out,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] stall_cycles_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_RUN     = 3'b001,
        S_FLUSH   = 3'b010,
        S_MEMWAIT = 3'b011,
        S_LDSTALL = 3'b100,
        S_FWAIT   = 3'b101
    } state_t;

    // Wide enough to reach WAIT_LIMIT; with the timeout disabled the value is never compared.
    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t            state;
    state_t            action;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              hazard;
    logic              timeout;
    // {pc_hold, reg1_en, reg1_flush, reg2_en, reg2_flush}
    logic [4:0]        ctl;

    always_comb begin
        hazard = ex_load_in && (ex_rd_addr_in != 5'd0) &&
                 ((id_rs1_used_in && (id_rs1_addr_in == ex_rd_addr_in)) ||
                  (id_rs2_used_in && (id_rs2_addr_in == ex_rd_addr_in)));
        timeout = (WAIT_LIMIT != 0) && !data_hready_in &&
                  (wait_cnt == WAIT_W'(WAIT_LIMIT));
    end

    // Action selection. A branch seen while the data bus is stalled is dropped:
    // stage 2 stays frozen and presents it again once the bus is ready.
    always_comb begin
        action = S_RUN;
        ctl    = 5'b01010;
        if ((state == S_IDLE) || trap_taken_in || timeout ||
            (branch_taken_in && data_hready_in)) begin
            action = S_FLUSH;
            ctl    = 5'b01111;
        end else if (!data_hready_in) begin
            action = S_MEMWAIT;
            ctl    = 5'b10000;
        end else if (hazard) begin
            action = S_LDSTALL;
            ctl    = 5'b10011;
        end else if (!instr_hready_in) begin
            // Stage 1 takes a bubble while stage 2 keeps draining.
            action = S_FWAIT;
            ctl    = 5'b11110;
        end
    end

    // Reset forces the safe hold/bubble pattern regardless of the IDLE->FLUSH decode.
    always_comb begin
        pc_hold_out    = !reset_n_in || ctl[4];
        reg1_en_out    =  reset_n_in && ctl[3];
        reg1_flush_out = !reset_n_in || ctl[2];
        reg2_en_out    =  reset_n_in && ctl[1];
        reg2_flush_out = !reset_n_in || ctl[0];
        bus_err_out    =  reset_n_in && timeout;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= action;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wait_cnt <= '0;
        end else if (action == S_MEMWAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stall_cnt <= '0;
        end else if (perf_clr_in) begin
            stall_cnt <= '0;
        end else if (pc_hold_out && (state != S_IDLE) && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign state_out        = state;
    assign stall_cycles_out = stall_cnt;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
module tb_msrv32_pipe_ctrl;

    logic        clk_in;
    logic        reset_n_in;
    logic        instr_hready_in;
    logic        data_hready_in;
    logic        branch_taken_in;
    logic        trap_taken_in;
    logic        ex_load_in;
    logic [4:0]  ex_rd_addr_in;
    logic [4:0]  id_rs1_addr_in;
    logic [4:0]  id_rs2_addr_in;
    logic        id_rs1_used_in;
    logic        id_rs2_used_in;
    logic        perf_clr_in;
    logic        pc_hold_out;
    logic        reg1_en_out;
    logic        reg1_flush_out;
    logic        reg2_en_out;
    logic        reg2_flush_out;
    logic        bus_err_out;
    logic [2:0]  state_out;
    logic [15:0] stall_cycles_out;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] O_RESET = 5'b10101;
    localparam logic [4:0] O_FLUSH = 5'b01111;
    localparam logic [4:0] O_MEMW  = 5'b10000;
    localparam logic [4:0] O_LDST  = 5'b10011;
    localparam logic [4:0] O_FWAIT = 5'b11110;
    localparam logic [4:0] O_RUN   = 5'b01010;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_RUN  = 3'b001;
    localparam logic [2:0] ST_FL   = 3'b010;
    localparam logic [2:0] ST_MW   = 3'b011;
    localparam logic [2:0] ST_LD   = 3'b100;
    localparam logic [2:0] ST_FW   = 3'b101;

    logic [4:0] ctl;
    assign ctl = {pc_hold_out, reg1_en_out, reg1_flush_out, reg2_en_out, reg2_flush_out};

    msrv32_pipe_ctrl #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
        .clk_in           (clk_in),
        .reset_n_in       (reset_n_in),
        .instr_hready_in  (instr_hready_in),
        .data_hready_in   (data_hready_in),
        .branch_taken_in  (branch_taken_in),
        .trap_taken_in    (trap_taken_in),
        .ex_load_in       (ex_load_in),
        .ex_rd_addr_in    (ex_rd_addr_in),
        .id_rs1_addr_in   (id_rs1_addr_in),
        .id_rs2_addr_in   (id_rs2_addr_in),
        .id_rs1_used_in   (id_rs1_used_in),
        .id_rs2_used_in   (id_rs2_used_in),
        .perf_clr_in      (perf_clr_in),
        .pc_hold_out      (pc_hold_out),
        .reg1_en_out      (reg1_en_out),
        .reg1_flush_out   (reg1_flush_out),
        .reg2_en_out      (reg2_en_out),
        .reg2_flush_out   (reg2_flush_out),
        .bus_err_out      (bus_err_out),
        .state_out        (state_out),
        .stall_cycles_out (stall_cycles_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_hazard();
        ex_load_in     = 1'b0;
        ex_rd_addr_in  = 5'd0;
        id_rs1_addr_in = 5'd0;
        id_rs2_addr_in = 5'd0;
        id_rs1_used_in = 1'b0;
        id_rs2_used_in = 1'b0;
    endtask

    initial begin
        reset_n_in      = 1'b0;
        instr_hready_in = 1'b0;
        data_hready_in  = 1'b1;
        branch_taken_in = 1'b0;
        trap_taken_in   = 1'b0;
        perf_clr_in     = 1'b0;
        clear_hazard();

        // Reset values
        repeat (2) @(negedge clk_in);
        check("rst_ctl",   32'(ctl), 32'(O_RESET));
        check("rst_state", 32'(state_out), 32'(ST_IDLE));
        check("rst_stall", 32'(stall_cycles_out), 32'd0);
        check("rst_err",   32'(bus_err_out), 32'd0);

        // Release during a fetch wait: FLUSH from IDLE, then FWAIT until ready
        #2 reset_n_in = 1'b1;
        #1;
        check("rel_flush", 32'(ctl), 32'(O_FLUSH));
        check("rel_state", 32'(state_out), 32'(ST_IDLE));
        tick(); @(negedge clk_in);
        check("fw1_ctl",   32'(ctl), 32'(O_FWAIT));
        check("fw1_state", 32'(state_out), 32'(ST_FL));
        check("fw1_stall", 32'(stall_cycles_out), 32'd0);
        tick(); @(negedge clk_in);
        check("fw2_ctl",   32'(ctl), 32'(O_FWAIT));
        check("fw2_state", 32'(state_out), 32'(ST_FW));
        check("fw2_stall", 32'(stall_cycles_out), 32'd1);
        tick(); instr_hready_in = 1'b1; @(negedge clk_in);
        check("run_ctl",   32'(ctl), 32'(O_RUN));
        check("run_stall", 32'(stall_cycles_out), 32'd2);

        // Load-use hazard on rs1: one LDSTALL cycle then RUN
        tick();
        ex_load_in = 1'b1; ex_rd_addr_in = 5'd5; id_rs1_addr_in = 5'd5; id_rs1_used_in = 1'b1;
        @(negedge clk_in);
        check("ld_ctl",   32'(ctl), 32'(O_LDST));
        check("ld_state", 32'(state_out), 32'(ST_RUN));
        tick(); clear_hazard(); @(negedge clk_in);
        check("ld_after_ctl",   32'(ctl), 32'(O_RUN));
        check("ld_after_state", 32'(state_out), 32'(ST_LD));
        check("ld_after_stall", 32'(stall_cycles_out), 32'd3);

        // rd = x0 never stalls
        tick();
        ex_load_in = 1'b1; ex_rd_addr_in = 5'd0; id_rs1_addr_in = 5'd0; id_rs1_used_in = 1'b1;
        @(negedge clk_in);
        check("rd0_ctl", 32'(ctl), 32'(O_RUN));

        // Matching rs2 that is not read does not stall
        tick(); clear_hazard();
        ex_load_in = 1'b1; ex_rd_addr_in = 5'd5; id_rs1_addr_in = 5'd3; id_rs1_used_in = 1'b1;
        id_rs2_addr_in = 5'd5; id_rs2_used_in = 1'b0;
        @(negedge clk_in);
        check("rs2_unused_ctl", 32'(ctl), 32'(O_RUN));

        // Same operand read through rs2 does stall
        tick(); id_rs2_used_in = 1'b1; @(negedge clk_in);
        check("rs2_used_ctl", 32'(ctl), 32'(O_LDST));

        // Branch and hazard together: FLUSH wins
        tick(); clear_hazard();
        ex_load_in = 1'b1; ex_rd_addr_in = 5'd7; id_rs1_addr_in = 5'd7; id_rs1_used_in = 1'b1;
        branch_taken_in = 1'b1;
        @(negedge clk_in);
        check("br_haz_ctl", 32'(ctl), 32'(O_FLUSH));
        tick(); clear_hazard(); branch_taken_in = 1'b0; @(negedge clk_in);
        check("br_haz_state", 32'(state_out), 32'(ST_FL));
        check("br_haz_next",  32'(ctl), 32'(O_RUN));
        check("br_haz_stall", 32'(stall_cycles_out), 32'd4);

        // Three data-wait cycles; a branch during the wait is ignored
        tick(); data_hready_in = 1'b0; @(negedge clk_in);
        check("mw1_ctl", 32'(ctl), 32'(O_MEMW));
        tick(); branch_taken_in = 1'b1; @(negedge clk_in);
        check("mw2_ctl",   32'(ctl), 32'(O_MEMW));
        check("mw2_state", 32'(state_out), 32'(ST_MW));
        tick(); branch_taken_in = 1'b0; @(negedge clk_in);
        check("mw3_ctl", 32'(ctl), 32'(O_MEMW));
        tick(); data_hready_in = 1'b1; @(negedge clk_in);
        check("mw_done_ctl",   32'(ctl), 32'(O_RUN));
        check("mw_done_state", 32'(state_out), 32'(ST_MW));
        check("mw_done_stall", 32'(stall_cycles_out), 32'd7);

        // Trap overrides a data wait
        tick(); data_hready_in = 1'b0; trap_taken_in = 1'b1; @(negedge clk_in);
        check("trap_ctl", 32'(ctl), 32'(O_FLUSH));
        tick(); data_hready_in = 1'b1; trap_taken_in = 1'b0; @(negedge clk_in);
        check("trap_state", 32'(state_out), 32'(ST_FL));
        check("trap_stall", 32'(stall_cycles_out), 32'd7);

        // Clear beats increment in a held cycle
        tick(); data_hready_in = 1'b0; perf_clr_in = 1'b1; @(negedge clk_in);
        check("clr_ctl", 32'(ctl), 32'(O_MEMW));
        tick(); data_hready_in = 1'b1; perf_clr_in = 1'b0; @(negedge clk_in);
        check("clr_stall", 32'(stall_cycles_out), 32'd0);

        // Timeout: 15 waits, error+FLUSH on the 16th, then counting restarts
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) data_hready_in = 1'b0;
            @(negedge clk_in);
            check($sformatf("to_err_%0d", i), 32'(bus_err_out), (i == 16) ? 32'd1 : 32'd0);
            check($sformatf("to_ctl_%0d", i), 32'(ctl), (i == 16) ? 32'(O_FLUSH) : 32'(O_MEMW));
        end
        tick(); data_hready_in = 1'b1; @(negedge clk_in);
        check("to_done_ctl",   32'(ctl), 32'(O_RUN));
        check("to_done_stall", 32'(stall_cycles_out), 32'd19);

        // Reset in the middle of a data wait aborts to IDLE values, no error
        tick(); data_hready_in = 1'b0; @(negedge clk_in);
        check("mwr_ctl", 32'(ctl), 32'(O_MEMW));
        #1 reset_n_in = 1'b0;
        #1;
        check("mwr_rst_ctl",   32'(ctl), 32'(O_RESET));
        check("mwr_rst_state", 32'(state_out), 32'(ST_IDLE));
        check("mwr_rst_err",   32'(bus_err_out), 32'd0);
        check("mwr_rst_stall", 32'(stall_cycles_out), 32'd0);
        data_hready_in = 1'b1;
        @(negedge clk_in);
        #2 reset_n_in = 1'b1;
        #1;
        check("rel2_ctl", 32'(ctl), 32'(O_FLUSH));
        tick(); @(negedge clk_in);
        check("rel2_run_ctl",   32'(ctl), 32'(O_RUN));
        check("rel2_run_state", 32'(state_out), 32'(ST_FL));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv32_pipe_ctrl.md
MSRV32_PIPE_CTRL -- requirements
Module: msrv32_pipe_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum consecutive data-wait cycles before timeout; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk_in  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n_in  input  1  asynchronous, active-low reset.
REQ-005 instr_hready_in  input  1  instruction bus ready; 0 = fetch not complete.
REQ-006 data_hready_in  input  1  data bus ready; 0 = load/store in stage 3 not complete.
REQ-007 branch_taken_in  input  1  branch/jump resolved taken in stage 2.
REQ-008 trap_taken_in  input  1  trap/interrupt entry this cycle.
REQ-009 ex_load_in  input  1  instruction held in reg_block_2 is a load.
REQ-010 ex_rd_addr_in  input  5  destination register of that instruction.
REQ-011 id_rs1_addr_in, id_rs2_addr_in  input  5 each  source registers decoded in stage 2.
REQ-012 id_rs1_used_in, id_rs2_used_in  input  1 each  source register actually read.
REQ-013 perf_clr_in  input  1  synchronous clear of stall counter.
REQ-014 pc_hold_out  output  1  PC register keeps its value.
REQ-015 reg1_en_out / reg1_flush_out  output  1 each  reg_block_1 load enable / load a bubble (NOP).
REQ-016 reg2_en_out / reg2_flush_out  output  1 each  reg_block_2 load enable / load a bubble (rf_wr_en, csr_wr_en forced 0).
REQ-017 bus_err_out  output  1  one-cycle pulse on data-wait timeout.
REQ-018 state_out  output  3  current state encoding.
REQ-019 stall_cycles_out  output  CNT_W  saturating count of cycles with pc_hold_out=1.

Function
REQ-020 States (encoding): IDLE=000, RUN=001, FLUSH=010, MEMWAIT=011, LDSTALL=100, FWAIT=101; state register holds the action taken in the previous cycle.
REQ-021 hazard = ex_load_in & (ex_rd_addr_in!=0) & ((id_rs1_used_in & rs1==rd) | (id_rs2_used_in & rs2==rd)).
REQ-022 Action each cycle chosen combinationally by strict priority: (1) FLUSH if state==IDLE, trap_taken_in, timeout, or (branch_taken_in & data_hready_in); (2) MEMWAIT if !data_hready_in; (3) LDSTALL if hazard; (4) FWAIT if !instr_hready_in; (5) RUN.
REQ-023 Outputs (pc_hold, reg1_en, reg1_flush, reg2_en, reg2_flush): FLUSH=0,1,1,1,1; MEMWAIT=1,0,0,0,0; LDSTALL=1,0,0,1,1; FWAIT=1,1,1,1,0; RUN=0,1,0,1,0.
REQ-024 Next state = selected action; LDSTALL and FLUSH therefore last exactly one cycle unless their cause persists.
REQ-025 branch_taken_in while data_hready_in=0 is ignored; the frozen stage re-presents it when ready returns.
REQ-026 trap_taken_in overrides MEMWAIT in the same cycle.
REQ-027 Wait counter clears on any non-MEMWAIT action, increments each MEMWAIT action; timeout = (WAIT_LIMIT!=0) & !data_hready_in & (count==WAIT_LIMIT).
REQ-028 On timeout: bus_err_out=1 that cycle only, action FLUSH, counter cleared.
REQ-029 stall_cycles_out increments when pc_hold_out=1 and state!=IDLE, saturates at all-ones; perf_clr_in wins over increment.
REQ-030 Outputs are Mealy: a hazard or wait stalls in the same cycle it is presented.

Reset
REQ-031 While reset_n_in=0: state=IDLE, wait counter=0, stall_cycles_out=0, bus_err_out=0, pc_hold_out=1, reg1_en_out=reg2_en_out=0, reg1_flush_out=reg2_flush_out=1.
REQ-032 First cycle after release: action FLUSH (from IDLE), then normal priority.
REQ-033 Reset asserted mid-MEMWAIT or mid-FLUSH aborts immediately to IDLE values, no bus_err_out.

Verification
REQ-034 ex_load_in=1, rd=5, rs1=5, rs1_used=1 -> one cycle LDSTALL (pc_hold=1, reg1_en=0, reg2_flush=1), then RUN.
REQ-035 Same with rd=0 -> no stall; rs2=5 with rs2_used=0 -> no stall.
REQ-036 branch_taken_in=1 and hazard together -> FLUSH wins, outputs 0,1,1,1,1, state_out=010 next cycle.
REQ-037 data_hready_in=0 for 3 cycles -> MEMWAIT 3 cycles, all enables 0, stall_cycles_out +3, RUN after.
REQ-038 data_hready_in=0 held 20 cycles, WAIT_LIMIT=15 -> bus_err_out pulse on 16th wait cycle, FLUSH, wait count restarts.
REQ-039 Reset released during instr_hready_in=0 -> FLUSH cycle, then FWAIT (1,1,1,1,0) until ready.
